// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants
package uart_pkg;
    localparam int DATA_W     = 8;
    localparam int OVERSAMPLE = 16;
    localparam int FIFO_DEPTH = 16;
endpackage

// File: rtl/uart_fifo_ram.sv
// rtl/uart_fifo_ram.sv - DEPTH x 8 storage, synchronous write, registered read
module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read-before-write: a same-address write this cycle is not seen until later.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive byte FIFO with rx_done edge detect and sticky overflow
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_done,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [AW:0]       count,
    output logic              overflow,
    input  logic              ovf_clr
);

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic          rx_prev;
    logic          rx_armed;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_evt;
    logic          rd_accept;
    logic          wr_accept;
    logic          ovf_set;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // rx_armed keeps an rx_done held across reset release from looking like a fresh edge.
    always_comb begin
        wr_evt    = rx_done & ~rx_prev & rx_armed;
        rd_accept = rd_en & ~empty;
        wr_accept = wr_evt & (~full | rd_accept);
        ovf_set   = wr_evt & full & ~rd_accept;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_prev  <= 1'b0;
            rx_armed <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            rx_prev  <= rx_done;
            rx_armed <= 1'b1;
            rd_valid <= rd_accept;
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    uart_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_accept & ~reset),
        .wr_addr (wr_ptr),
        .wr_data (rx_data),
        .rd_en   (rd_accept & ~reset),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo against a queue model
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;
    logic       ovf_clr;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] q[$];
    bit         m_prev;
    bit         m_ovf;
    bit         m_valid;
    logic [7:0] m_data;

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_done  (rx_done),
        .rx_data  (rx_data),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // After reset the model treats rx_done as previously high, so only a genuine
    // low-to-high transition seen after release counts as a byte.
    task automatic model(input bit rxd, input logic [7:0] d, input bit rde, input bit clr, input bit rst);
        bit evt;
        bit rd_ok;
        bit drop;
        int n;
        if (rst) begin
            q.delete();
            m_prev  = 1'b1;
            m_ovf   = 1'b0;
            m_valid = 1'b0;
            m_data  = 8'h00;
        end else begin
            n     = q.size();
            evt   = rxd && !m_prev;
            rd_ok = rde && (n > 0);
            drop  = 1'b0;
            m_valid = rd_ok;
            if (rd_ok) m_data = q.pop_front();
            if (evt) begin
                if (n < DEPTH || rd_ok) q.push_back(d);
                else drop = 1'b1;
            end
            if (drop) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
            m_prev = rxd;
        end
    endtask

    task automatic cyc(input bit rxd, input logic [7:0] d, input bit rde, input bit clr, input bit rst);
        reset   = rst;
        rx_done = rxd;
        rx_data = d;
        rd_en   = rde;
        ovf_clr = clr;
        @(posedge clk);
        #1;
        model(rxd, d, rde, clr, rst);
        chk("rd_valid", 32'(rd_valid), 32'(m_valid));
        chk("rd_data",  32'(rd_data),  32'(m_data));
        chk("count",    32'(count),    32'(q.size()));
        chk("empty",    32'(empty),    32'(q.size() == 0));
        chk("full",     32'(full),     32'(q.size() == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic wr(input logic [7:0] d);
        cyc(1'b1, d, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd();
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        // reset and arm edge detector
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_data",  32'(rd_data), 0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // single byte round trip
        cyc(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        chk("a5_count1", 32'(count), 1);
        chk("a5_nempty", 32'(empty), 0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("a5_valid", 32'(rd_valid), 1);
        chk("a5_data",  32'(rd_data), 32'h A5);
        chk("a5_empty", 32'(empty), 1);

        // held rx_done writes once; read on empty is ignored
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("hold_count", 32'(count), 1);
        rd();
        chk("hold_data", 32'(rd_data), 32'h3C);
        rd();
        chk("empty_rd_valid", 32'(rd_valid), 0);
        chk("empty_rd_held",  32'(rd_data), 32'h3C);

        // fill, overflow, drain in order
        for (int i = 0; i < 16; i++) wr(8'(i));
        chk("fill_full",  32'(full), 1);
        chk("fill_count", 32'(count), 16);
        wr(8'hFF);
        chk("ovf_set",   32'(overflow), 1);
        chk("ovf_count", 32'(count), 16);
        for (int i = 0; i < 16; i++) begin
            rd();
            chk("seq_data", 32'(rd_data), 32'(i));
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("ovf_clr", 32'(overflow), 0);

        // simultaneous write and read while full
        for (int i = 0; i < 16; i++) wr(8'($urandom_range(0, 255)));
        cyc(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        chk("rw_full_count", 32'(count), 16);
        chk("rw_full_ovf",   32'(overflow), 0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) rd();
        chk("rw_last_55", 32'(rd_data), 32'h55);

        // pointer wrap
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 10; i++) wr(8'($urandom_range(0, 255)));
            for (int i = 0; i < 10; i++) rd();
        end

        // overflow event coinciding with clear: set wins
        for (int i = 0; i < 16; i++) wr(8'($urandom_range(0, 255)));
        cyc(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
        chk("ovf_set_wins", 32'(overflow), 1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) rd();

        // reset mid-stream, rx_done held across release
        for (int i = 0; i < 7; i++) wr(8'($urandom_range(0, 255)));
        chk("mid_count7", 32'(count), 7);
        cyc(1'b1, 8'h77, 1'b1, 1'b1, 1'b1);
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_empty", 32'(empty), 1);
        chk("mid_rst_valid", 32'(rd_valid), 0);
        cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        chk("rel_no_write", 32'(count), 0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        wr(8'h12);
        chk("rel_write_ok", 32'(count), 1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 1) == 1),
                8'($urandom_range(0, 255)),
                ($urandom_range(0, 9) < 4),
                ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 99) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL use a single clock and a single reset; reset is synchronous and active-high.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning the number of stored bytes; it must be a power of two, 4..256.
REQ-003 The block SHALL have parameter AW, default $clog2(DEPTH), meaning the pointer width.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 rx_done  input  1  byte-complete indication from the UART receiver (pulse or held level).
REQ-007 rx_data  input  8  received byte; valid while rx_done high.
REQ-008 rd_en  input  1  consumer read request.
REQ-009 rd_data  output  8  registered read byte.
REQ-010 rd_valid  output  1  one-cycle strobe; rd_data valid.
REQ-011 empty  output  1  no bytes stored.
REQ-012 full  output  1  DEPTH bytes stored.
REQ-013 count  output  AW+1  bytes stored, 0..DEPTH.
REQ-014 overflow  output  1  sticky; a byte was dropped.
REQ-015 ovf_clr  input  1  clears overflow.

Function
REQ-016 A write event SHALL be the rising edge of rx_done, i.e. rx_done=1 with the registered previous rx_done=0; a held-high rx_done SHALL produce exactly one write.
REQ-017 A write event with full=0 SHALL store rx_data at wr_ptr, and wr_ptr SHALL increment modulo DEPTH.
REQ-018 A read with rd_en=1 and empty=0 SHALL present mem[rd_ptr] on rd_data with rd_valid=1 on the next cycle, and rd_ptr SHALL increment modulo DEPTH.
REQ-019 A read with rd_en=1 and empty=1 SHALL be ignored: no pointer change, rd_valid=0, and rd_data held.
REQ-020 rd_data SHALL hold its last value when rd_valid=0.
REQ-021 count SHALL be +1 on write only, -1 on read only, and unchanged on simultaneous accepted write and read; empty=(count==0), full=(count==DEPTH), both derived from registered count.
REQ-022 With a write event and a read in the same cycle while full=1, both SHALL be accepted, count SHALL stay DEPTH, and overflow SHALL be unchanged.
REQ-023 With a write event and a read in the same cycle while empty=1, the write SHALL be accepted and the read ignored; there is no fall-through, and the earliest read of that byte is the next cycle.
REQ-024 A write event with full=1 and no read SHALL drop the byte, leave memory and pointers unchanged, and set overflow=1 the next cycle.
REQ-025 overflow SHALL clear on ovf_clr=1; if an overflow event and ovf_clr coincide, set SHALL win.
REQ-026 Pointer wrap SHALL occur naturally at DEPTH-1 to 0, and ordering SHALL remain strict FIFO across the wrap.
REQ-027 Latency SHALL be: write edge to empty=0 in 1 cycle; rd_en to rd_valid in 1 cycle.

Reset
REQ-028 On reset=1 at a clock edge: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overflow=0, rd_valid=0, rd_data=8'h00, previous-rx_done register=0.
REQ-029 Reset SHALL override all simultaneous write, read, and clear activity; memory contents need not be cleared.
REQ-030 An rx_done still high when reset releases SHALL NOT produce a write, because the previous-value register must first see 0.

Structure
REQ-031 The shared package uart_pkg SHALL hold DATA_W=8, OVERSAMPLE=16, and the default FIFO depth constant.
REQ-032 Storage SHALL be one sub-module, uart_fifo_ram: a DEPTH x 8 array with a synchronous write port and a registered read port, with no reset on the array.
REQ-033 Edge detection, pointers, count, flags, and overflow logic SHALL reside in uart_rx_fifo.

Verification
REQ-034 Reset, write 8'hA5 (1-cycle rx_done), then rd_en -> rd_valid=1 with rd_data=8'hA5 next cycle; count goes 0->1->0 and empty returns to 1.
REQ-035 Hold rx_done high 5 cycles with rx_data=8'h3C -> count=1 exactly; a second read on empty gives rd_valid=0.
REQ-036 Write 16 bytes 8'h00..8'h0F -> full=1, count=16; a 17th write 8'hFF -> overflow=1, count=16; reading 16 times -> 8'h00..8'h0F in order with no 8'hFF.
REQ-037 With full, issue simultaneous write 8'h55 and read -> count stays 16, overflow=0; drain the FIFO -> 8'h55 comes last.
REQ-038 Write 10, read 10, write 10, read 10 (pointer wrap) -> order preserved; ovf_clr coinciding with an overflow event -> overflow=1.
REQ-039 Assert reset mid-stream with count=7 -> next cycle count=0, empty=1, rd_valid=0; rx_done high across reset release -> no write.
